// File: rtl/fmap_pingpong_buf.sv
// Double-buffered feature-map store: producer fills one bank through two write
// ports while the consumer drains the other through two pipelined read ports.
module fmap_pingpong_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [DATA_WIDTH-1:0] wr_data_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_data_b,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  wr_bank, rd_bank;
  logic [1:0]            full, full_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

  logic [1:0]                 rd_en_v;
  logic [1:0][ADDR_WIDTH-1:0] rd_addr_v;
  logic [1:0][DATA_WIDTH-1:0] rd_q;
  logic [1:0]                 rd_vld;

  assign wr_ready = !full[wr_bank];
  assign rd_ready = full[rd_bank];
  assign wr_acc   = wr_done & wr_ready;
  assign rd_acc   = rd_done & rd_ready;

  // Both handshakes may land together; they always target different banks.
  always_comb begin
    full_nxt = full;
    if (wr_acc) full_nxt[wr_bank] = 1'b1;
    if (rd_acc) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      full    <= full_nxt;
      if (wr_acc) wr_bank <= ~wr_bank;
      if (rd_acc) rd_bank <= ~rd_bank;
      if ((wr_en_a | wr_en_b | wr_done) & !wr_ready) ovf_err <= 1'b1;
      if ((rd_en_a | rd_en_b | rd_done) & !rd_ready) udf_err <= 1'b1;
    end
  end

  // Port B is written first so port A wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ready) begin
      if (wr_en_b) mem[{wr_bank, wr_addr_b}] <= wr_data_b;
      if (wr_en_a) mem[{wr_bank, wr_addr_a}] <= wr_data_a;
    end
  end

  assign rd_en_v   = {rd_en_b, rd_en_a};
  assign rd_addr_v = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic                  acc;
    logic                  vld1;
    logic [DATA_WIDTH-1:0] d1;

    assign acc = rd_en_v[p] & rd_ready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld1 <= 1'b0;
        d1   <= '0;
      end else begin
        vld1 <= acc;
        if (acc) d1 <= mem[{rd_bank, rd_addr_v[p]}];
      end
    end

    if (READ_LAT == 2) begin : g_lat2
      logic                  vld2;
      logic [DATA_WIDTH-1:0] d2;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld2 <= 1'b0;
          d2   <= '0;
        end else begin
          vld2 <= vld1;
          if (vld1) d2 <= d1;
        end
      end
      assign rd_q[p]   = d2;
      assign rd_vld[p] = vld2;
    end else begin : g_lat1
      assign rd_q[p]   = d1;
      assign rd_vld[p] = vld1;
    end
  end

  assign rd_data_a  = rd_q[0];
  assign rd_data_b  = rd_q[1];
  assign rd_valid_a = rd_vld[0];
  assign rd_valid_b = rd_vld[1];

endmodule
